irq_ctl: RTL and testbench
==========================

Name: irq_ctl

Overview:
- Interrupt conditioning stage directly upstream of the 65C02 core. It drives the core's IRQ and NMI inputs from raw asynchronous board sources.
- Synchronises and masks 8 IRQ sources, each configurable as level or latched rising-edge.
- Edge-detects one NMI source and holds the request until the core fetches the NMI vector.
- Exposes 4 memory-mapped byte registers on the core bus (AD/DO/WE), with registered read data for the system DI mux.

Parameters:
- BASE, 16'hFE00, register block base address; decode is AD[15:2] == BASE[15:2].
- NMI_VEC, 16'hFFFA, address whose read acknowledges NMI.

Ports:
- clk  input  1  CPU clock; all state on rising edge.
- RST  input  1  reset; synchronous, active-high.
- AD  input  16  core address bus (combinatorial from core).
- DO  input  8  core data output.
- WE  input  1  core write enable.
- irq_src  input  8  raw IRQ sources, active-high, asynchronous.
- nmi_src  input  1  raw NMI source, active-high, asynchronous; rising edge requests.
- IRQ  output  1  registered level IRQ request to core.
- NMI  output  1  registered NMI request to core, held until acknowledged.
- rd_data  output  8  registered register read data.
- rd_sel  output  1  registered; high when rd_data must drive DI this cycle.

Behaviour:
Reset (RST high at an edge):
- mask, edge_cfg, latch, all synchroniser flops, IRQ, NMI, rd_data and rd_sel all clear to 0.
- RST mid-operation discards pending edges and any NMI request.

Synchronisers:
- Each source passes through 2 flops (s1, s2), plus s3 = previous s2 for edge detect.
- rise[i] = s2[i] & ~s3[i].

Registers (offset = AD[1:0]):
- 0 STATUS: read-only. Returns mask & eff, where eff[i] = edge_cfg[i] ? latch[i] : s2[i].
- 1 MASK: r/w. 1 = enabled.
- 2 LATCH: read returns latch. Writing 1 clears the bit; writing 0 has no effect.
- 3 EDGE_CFG: r/w. 1 = edge, 0 = level. Writing a bit to 0 also clears latch for that bit.

Bus access:
- A write occurs at an edge with address match & WE.
- A read is an address match & ~WE. At the next edge, rd_sel <= 1 and rd_data <= selected register. This gives one-cycle read latency, matching synchronous RAM.
- Non-matching cycle: rd_sel <= 0 and rd_data holds its value.

Latch update:
- latch[i] <= (latch[i] & ~clr[i]) | (rise[i] & edge_cfg[i]).
- A set and a clear in the same cycle leaves the bit set.

IRQ:
- IRQ <= |(mask & (edge_cfg ? (latch | rise) : s2)).
- A source sampled high at edge k gives IRQ high after edge k+2, for both edge and level mode.
- A MASK write at edge w affects IRQ after edge w+1.
- IRQ is never cleared by vector fetch. Software clears the source or the latch.

NMI:
- Simple state machine with states IDLE and PEND.
  - IDLE -> PEND on nmi rise.
  - PEND -> IDLE on ack, where ack = (AD == NMI_VEC) & ~WE.
  - NMI = (state == PEND).
- A rise in the same cycle as an ack keeps PEND.
- A rise while already in PEND is absorbed.
- A level held high produces only one request.
- An ack while IDLE has no effect.

Timing and decode:
- All outputs are registered. No combinational path from AD to IRQ/NMI.
- Accesses outside the 4-byte window are ignored.

Test Plan:
- Reset, then read offsets 0–3 -> rd_sel pulses 1 cycle after each read; rd_data = 00 each time. IRQ = 0, NMI = 0.
- MASK=01, EDGE_CFG=00, irq_src[0] high at edge k -> IRQ=1 after edge k+2. Drop source -> IRQ=0 two edges later. STATUS reads 01 then 00.
- EDGE_CFG=04, MASK=04, pulse irq_src[2] high for 3 cycles -> IRQ=1 and stays 1 after the source drops; LATCH reads 04. Write 04 to LATCH -> IRQ=0 next edge. A rise coincident with the clear leaves LATCH=04.
- nmi_src rising, held high -> NMI=1 after 2 edges. Read FFFB -> NMI stays 1. Read FFFA -> NMI=0 next edge, no re-trigger while held. Drop then raise nmi_src -> NMI=1 again. A rise on the same cycle as the FFFA read leaves NMI=1.
- Write MASK=FF with all sources level-high, assert RST mid-run -> all outputs 0 after the RST edge. MASK reads 00; IRQ stays 0 until MASK is rewritten.

Source files
------------

// File: rtl/irq_ctl.sv
// Interrupt conditioning for the 65C02 core: synchronised, maskable IRQ sources
// (level or latched edge), edge-detected NMI held until vector fetch, 4-byte register window.
module irq_ctl #(
  parameter logic [15:0] BASE    = 16'hFE00,
  parameter logic [15:0] NMI_VEC = 16'hFFFA
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [15:0] AD,
  input  logic [7:0]  DO,
  input  logic        WE,
  input  logic [7:0]  irq_src,
  input  logic        nmi_src,
  output logic        IRQ,
  output logic        NMI,
  output logic [7:0]  rd_data,
  output logic        rd_sel
);

  typedef enum logic {
    NMI_IDLE = 1'b0,
    NMI_PEND = 1'b1
  } nmi_state_t;

  localparam logic [1:0] OFF_STATUS = 2'd0;
  localparam logic [1:0] OFF_MASK   = 2'd1;
  localparam logic [1:0] OFF_LATCH  = 2'd2;
  localparam logic [1:0] OFF_EDGE   = 2'd3;

  logic [7:0] r_irq_s1, r_irq_s2, r_irq_s3;
  logic       r_nmi_s1, r_nmi_s2, r_nmi_s3;
  logic [7:0] r_mask;
  logic [7:0] r_edge_cfg;
  logic [7:0] r_latch;
  logic       r_irq;
  logic [7:0] r_rd_data;
  logic       r_rd_sel;
  nmi_state_t r_nmi_state;
  nmi_state_t w_nmi_state_nxt;

  logic       w_hit, w_wr, w_rd, w_ack;
  logic [1:0] w_off;
  logic [7:0] w_rise;
  logic       w_nmi_rise;
  logic [7:0] w_eff;
  logic [7:0] w_clr;
  logic [7:0] w_latch_nxt;
  logic [7:0] w_irq_vec;
  logic [7:0] w_rd_mux;

  assign w_hit      = (AD[15:2] == BASE[15:2]);
  assign w_wr       = w_hit & WE;
  assign w_rd       = w_hit & ~WE;
  assign w_off      = AD[1:0];
  assign w_ack      = (AD == NMI_VEC) & ~WE;
  assign w_rise     = r_irq_s2 & ~r_irq_s3;
  assign w_nmi_rise = r_nmi_s2 & ~r_nmi_s3;

  assign w_eff     = (r_edge_cfg & r_latch) | (~r_edge_cfg & r_irq_s2);
  // Edge sources include this cycle's rise so edge and level mode share the same latency.
  assign w_irq_vec = r_mask & ((r_edge_cfg & (r_latch | w_rise)) | (~r_edge_cfg & r_irq_s2));

  always_comb begin
    w_clr = '0;
    if (w_wr && (w_off == OFF_LATCH)) w_clr = DO;
    if (w_wr && (w_off == OFF_EDGE))  w_clr = ~DO;
  end

  // Set term is OR-ed last so a rise wins over a same-cycle clear.
  assign w_latch_nxt = (r_latch & ~w_clr) | (w_rise & r_edge_cfg);

  always_comb begin
    w_rd_mux = '0;
    case (w_off)
      OFF_STATUS: w_rd_mux = r_mask & w_eff;
      OFF_MASK:   w_rd_mux = r_mask;
      OFF_LATCH:  w_rd_mux = r_latch;
      OFF_EDGE:   w_rd_mux = r_edge_cfg;
      default:    w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      r_irq_s1 <= '0;
      r_irq_s2 <= '0;
      r_irq_s3 <= '0;
      r_nmi_s1 <= 1'b0;
      r_nmi_s2 <= 1'b0;
      r_nmi_s3 <= 1'b0;
    end else begin
      r_irq_s1 <= irq_src;
      r_irq_s2 <= r_irq_s1;
      r_irq_s3 <= r_irq_s2;
      r_nmi_s1 <= nmi_src;
      r_nmi_s2 <= r_nmi_s1;
      r_nmi_s3 <= r_nmi_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      r_mask     <= '0;
      r_edge_cfg <= '0;
      r_latch    <= '0;
      r_irq      <= 1'b0;
    end else begin
      if (w_wr && (w_off == OFF_MASK)) r_mask     <= DO;
      if (w_wr && (w_off == OFF_EDGE)) r_edge_cfg <= DO;
      r_latch <= w_latch_nxt;
      r_irq   <= |w_irq_vec;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      r_rd_data <= '0;
      r_rd_sel  <= 1'b0;
    end else begin
      r_rd_sel <= w_rd;
      if (w_rd) r_rd_data <= w_rd_mux;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) r_nmi_state <= NMI_IDLE;
    else     r_nmi_state <= w_nmi_state_nxt;
  end

  always_comb begin
    w_nmi_state_nxt = r_nmi_state;
    case (r_nmi_state)
      NMI_IDLE: if (w_nmi_rise) w_nmi_state_nxt = NMI_PEND;
      NMI_PEND: if (w_ack && !w_nmi_rise) w_nmi_state_nxt = NMI_IDLE;
      default:  w_nmi_state_nxt = NMI_IDLE;
    endcase
  end

  assign IRQ     = r_irq;
  assign NMI     = (r_nmi_state == NMI_PEND);
  assign rd_data = r_rd_data;
  assign rd_sel  = r_rd_sel;

endmodule

// File: tb/tb_irq_ctl.sv
// Scoreboard bench for irq_ctl: stimulus queues expected reads and IRQ/NMI levels,
// a negedge monitor pops and compares them.
module tb_irq_ctl;

  localparam logic [15:0] BASE    = 16'hFE00;
  localparam logic [15:0] NMI_VEC = 16'hFFFA;

  logic        clk = 1'b0;
  logic        RST;
  logic [15:0] AD;
  logic [7:0]  DO;
  logic        WE;
  logic [7:0]  irq_src;
  logic        nmi_src;
  logic        IRQ, NMI;
  logic [7:0]  rd_data;
  logic        rd_sel;

  irq_ctl #(.BASE(BASE), .NMI_VEC(NMI_VEC)) dut (
    .clk(clk), .RST(RST), .AD(AD), .DO(DO), .WE(WE),
    .irq_src(irq_src), .nmi_src(nmi_src),
    .IRQ(IRQ), .NMI(NMI), .rd_data(rd_data), .rd_sel(rd_sel)
  );

  always #5 clk = ~clk;

  typedef struct { string name; logic [7:0] data; int cyc; } rd_exp_t;
  typedef struct { string name; logic irq; logic nmi; int cyc; } lvl_exp_t;

  rd_exp_t  rq[$];
  lvl_exp_t lq[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;
  logic rst_q = 1'b0;
  logic [7:0] last_rd = '0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= RST;
  end

  // Monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_q) last_rd = '0;
      while (lq.size() != 0 && lq[0].cyc <= cyc) begin
        lvl_exp_t e;
        e = lq.pop_front();
        checks++;
        if (IRQ !== e.irq || NMI !== e.nmi || e.cyc != cyc) begin
          errors++;
          $display("FAIL %s: IRQ=%b NMI=%b (cyc %0d), expected IRQ=%b NMI=%b (cyc %0d)",
                   e.name, IRQ, NMI, cyc, e.irq, e.nmi, e.cyc);
        end
      end
      if (rd_sel === 1'b1) begin
        checks++;
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rd_sel: rd_sel=1 rd_data=%h at cyc %0d, expected rd_sel=0", rd_data, cyc);
        end else begin
          rd_exp_t r;
          r = rq.pop_front();
          if (rd_data !== r.data || r.cyc != cyc) begin
            errors++;
            $display("FAIL %s: rd_data=%h at cyc %0d, expected %h at cyc %0d",
                     r.name, rd_data, cyc, r.data, r.cyc);
          end
          last_rd = r.data;
        end
      end else begin
        checks++;
        if (rd_sel !== 1'b0 || rd_data !== last_rd) begin
          errors++;
          $display("FAIL rd_hold: rd_sel=%b rd_data=%h at cyc %0d, expected rd_sel=0 rd_data=%h",
                   rd_sel, rd_data, cyc, last_rd);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] off, input logic [7:0] d);
    AD = BASE + 16'(off); DO = d; WE = 1'b1;
    tick();
    AD = 16'h0000; DO = 8'h00; WE = 1'b0;
  endtask

  task automatic rd(input logic [1:0] off, input logic [7:0] exp_d, input string nm);
    AD = BASE + 16'(off); WE = 1'b0;
    rq.push_back('{name: nm, data: exp_d, cyc: cyc + 1});
    tick();
    AD = 16'h0000;
  endtask

  task automatic bus_rd(input logic [15:0] a);
    AD = a; WE = 1'b0;
    tick();
    AD = 16'h0000;
  endtask

  task automatic chk(input string nm, input logic irq_e, input logic nmi_e);
    lq.push_back('{name: nm, irq: irq_e, nmi: nmi_e, cyc: cyc});
  endtask

  initial begin
    RST = 1'b1; AD = 16'h0000; DO = 8'h00; WE = 1'b0; irq_src = 8'h00; nmi_src = 1'b0;
    tick(); tick();
    RST = 1'b0;
    mon_en = 1'b1;
    chk("reset_out", 1'b0, 1'b0);
    rd(2'd0, 8'h00, "rst_status");
    rd(2'd1, 8'h00, "rst_mask");
    rd(2'd2, 8'h00, "rst_latch");
    rd(2'd3, 8'h00, "rst_edgecfg");
    tick();

    // Level mode on source 0
    wr(2'd1, 8'h01); wr(2'd3, 8'h00);
    irq_src = 8'h01;
    tick(); chk("lvl_k", 1'b0, 1'b0);
    tick(); chk("lvl_k1", 1'b0, 1'b0);
    tick(); chk("lvl_k2", 1'b1, 1'b0);
    rd(2'd0, 8'h01, "lvl_status_hi");
    wr(2'd1, 8'h00); chk("mask_off_w", 1'b1, 1'b0);
    tick();          chk("mask_off_w1", 1'b0, 1'b0);
    wr(2'd1, 8'h01); chk("mask_on_w", 1'b0, 1'b0);
    tick();          chk("mask_on_w1", 1'b1, 1'b0);
    irq_src = 8'h00;
    tick(); chk("lvl_drop1", 1'b1, 1'b0);
    tick(); chk("lvl_drop2", 1'b1, 1'b0);
    tick(); chk("lvl_drop3", 1'b0, 1'b0);
    rd(2'd0, 8'h00, "lvl_status_lo");

    // Edge mode on source 2
    wr(2'd1, 8'h00); wr(2'd3, 8'h04); wr(2'd1, 8'h04);
    irq_src = 8'h04;
    tick(); tick(); chk("edge_k1", 1'b0, 1'b0);
    tick(); chk("edge_k2", 1'b1, 1'b0);
    irq_src = 8'h00;
    tick(); tick(); tick(); chk("edge_hold", 1'b1, 1'b0);
    rd(2'd2, 8'h04, "latch_set");
    rd(2'd0, 8'h04, "status_edge");
    wr(2'd2, 8'h00);
    rd(2'd2, 8'h04, "latch_w0");
    wr(2'd2, 8'h04); chk("clr_edge", 1'b1, 1'b0);
    tick();          chk("clr_done", 1'b0, 1'b0);
    rd(2'd2, 8'h00, "latch_clr");
    irq_src = 8'h04;
    tick(); tick();
    wr(2'd2, 8'h04); chk("set_vs_clr_irq", 1'b1, 1'b0);
    irq_src = 8'h00;
    rd(2'd2, 8'h04, "set_wins");
    wr(2'd3, 8'h00);
    rd(2'd2, 8'h00, "cfg0_clr");
    rd(2'd3, 8'h00, "cfg_rd");
    tick(); chk("cfg0_irq", 1'b0, 1'b0);

    // NMI
    nmi_src = 1'b1;
    tick(); chk("nmi_k", 1'b0, 1'b0);
    tick(); chk("nmi_k1", 1'b0, 1'b0);
    tick(); chk("nmi_set", 1'b0, 1'b1);
    bus_rd(16'hFFFB); chk("nmi_fffb", 1'b0, 1'b1);
    bus_rd(NMI_VEC);  chk("nmi_ack", 1'b0, 1'b0);
    tick(); tick();   chk("nmi_held", 1'b0, 1'b0);
    bus_rd(NMI_VEC);  chk("nmi_ack_idle", 1'b0, 1'b0);
    nmi_src = 1'b0;
    tick(); tick(); tick();
    nmi_src = 1'b1;
    tick(); tick(); chk("nmi_rearm_pre", 1'b0, 1'b0);
    tick();         chk("nmi_rearm", 1'b0, 1'b1);
    nmi_src = 1'b0;
    tick(); tick(); tick();
    nmi_src = 1'b1;
    tick(); tick();
    bus_rd(NMI_VEC); chk("nmi_rise_ack", 1'b0, 1'b1);
    tick();          chk("nmi_rise_ack2", 1'b0, 1'b1);
    bus_rd(NMI_VEC); chk("nmi_ack2", 1'b0, 1'b0);

    // Reset mid-run
    irq_src = 8'hFF; nmi_src = 1'b0;
    wr(2'd3, 8'h00); wr(2'd1, 8'hFF);
    tick(); tick();
    nmi_src = 1'b1;
    tick(); tick(); tick(); chk("pre_rst", 1'b1, 1'b1);
    rd(2'd1, 8'hFF, "pre_rst_mask");
    RST = 1'b1; nmi_src = 1'b0;
    tick();
    RST = 1'b0;
    chk("rst_out_mid", 1'b0, 1'b0);
    tick(); tick(); tick(); chk("rst_mask0", 1'b0, 1'b0);
    rd(2'd1, 8'h00, "rst_mid_mask");
    rd(2'd2, 8'h00, "rst_mid_latch");
    wr(2'd1, 8'hFF); chk("remask_w", 1'b0, 1'b0);
    tick();          chk("remask_w1", 1'b1, 1'b0);
    rd(2'd0, 8'hFF, "status_all");

    tick(); tick(); tick();
    checks++;
    if (rq.size() != 0 || lq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d reads and %0d level checks pending, expected 0 and 0", rq.size(), lq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
